display_mux: RTL and testbench

- Downstream consumer of the stopwatch counter. Takes the binary seconds count (cont_seg, 0..999) and the tenths count (cont_dec, 0..9).
- Converts the seconds value to BCD with a sequential shift-add-3 engine.
- Time-multiplexes four active-low 7-segment digits, showing "SSS.d" with leading-zero blanking.
- Sits between the counter and the board pins.

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/display_mux.sv | 89 ++++++++
 tb/tb_display_mux.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants, FSM encoding and helpers for the stopwatch display path
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_ITER   = 10;
  localparam int SEC_MAX    = 999;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - free-running LOAD/SHIFT/DONE shift-add-3 converter, one result every 12 cycles
module bin2bcd_seq
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_bin,
  input  logic [3:0] i_dec,
  output logic [3:0] o_h,
  output logic [3:0] o_t,
  output logic [3:0] o_u,
  output logic [3:0] o_d,
  output logic       o_ovf,
  output logic       o_bcd_valid
);

  conv_state_t r_state, w_next;
  logic [21:0] r_shift;
  logic [3:0]  r_iter;
  logic [3:0]  r_dec_s;
  logic        r_ovf_s;
  logic [3:0]  r_h, r_t, r_u, r_d;
  logic        r_ovf, r_bcd_valid;

  logic        w_over;
  logic [9:0]  w_bin_c;
  logic [3:0]  w_dec_c;
  logic [21:0] w_adj;

  assign w_over  = (i_bin > 10'(SEC_MAX));
  assign w_bin_c = w_over ? 10'(SEC_MAX) : i_bin;
  assign w_dec_c = (i_dec > 4'd9) ? 4'd9 : i_dec;
  assign w_adj   = {add3(r_shift[21:18]), add3(r_shift[17:14]), add3(r_shift[13:10]), r_shift[9:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: if (r_iter == 4'(BCD_ITER - 1)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_LOAD;
      default:  w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= '0;
      r_iter      <= '0;
      r_dec_s     <= '0;
      r_ovf_s     <= 1'b0;
      r_h         <= '0;
      r_t         <= '0;
      r_u         <= '0;
      r_d         <= '0;
      r_ovf       <= 1'b0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          // Seconds and tenths are captured together so the display never tears
          r_shift <= {12'b0, w_bin_c};
          r_iter  <= '0;
          r_dec_s <= w_dec_c;
          r_ovf_s <= w_over;
        end
        ST_SHIFT: begin
          r_shift <= {w_adj[20:0], 1'b0};
          r_iter  <= r_iter + 4'd1;
        end
        ST_DONE: begin
          r_h         <= r_shift[21:18];
          r_t         <= r_shift[17:14];
          r_u         <= r_shift[13:10];
          r_d         <= r_dec_s;
          r_ovf       <= r_ovf_s;
          r_bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_h         = r_h;
  assign o_t         = r_t;
  assign o_u         = r_u;
  assign o_d         = r_d;
  assign o_ovf       = r_ovf;
  assign o_bcd_valid = r_bcd_valid;

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - four-digit active-low 7-segment scanner showing "SSS.d" with leading-zero blanking
module display_mux
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            cont_seg,
  input  logic [3:0]            cont_dec,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  bcd_valid,
  output logic                  ovf
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0] w_h, w_t, w_u, w_d;
  logic [SCW-1:0] r_scan;
  logic [1:0]     r_idx;
  logic [6:0]     r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic           r_dp;
  logic [3:0]     w_digit;
  logic           w_blank;

  bin2bcd_seq u_bin2bcd (
    .clk         (clk),
    .reset       (reset),
    .i_bin       (cont_seg),
    .i_dec       (cont_dec),
    .o_h         (w_h),
    .o_t         (w_t),
    .o_u         (w_u),
    .o_d         (w_d),
    .o_ovf       (ovf),
    .o_bcd_valid (bcd_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCW'(SCAN_DIV - 1)) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  always_comb begin
    w_digit = w_d;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: w_digit = w_d;
      2'd1: w_digit = w_u;
      2'd2: begin
        w_digit = w_t;
        w_blank = (BLANK_LZ != 0) && (w_h == 4'd0) && (w_t == 4'd0);
      end
      default: begin
        w_digit = w_h;
        w_blank = (BLANK_LZ != 0) && (w_h == 4'd0);
      end
    endcase
  end

  // Pin drivers are registered so the board sees glitch-free segment/anode changes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_blank ? SEG_BLANK : seg_of(w_digit);
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_dp  <= (r_idx != 2'd1);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - randomized check of display_mux against a digit-level reference model
module tb_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] cont_seg = '0;
  logic [3:0] cont_dec = '0;

  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic       dp0, dp1, bv0, bv1, ovf0, ovf1;

  always #5 clk = ~clk;

  display_mux #(.SCAN_DIV(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .reset(reset), .cont_seg(cont_seg), .cont_dec(cont_dec),
    .seg(seg0), .an(an0), .dp(dp0), .bcd_valid(bv0), .ovf(ovf0)
  );

  display_mux #(.SCAN_DIV(1), .BLANK_LZ(0)) dut1 (
    .clk(clk), .reset(reset), .cont_seg(cont_seg), .cont_dec(cont_dec),
    .seg(seg1), .an(an1), .dp(dp1), .bcd_valid(bv1), .ovf(ovf1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: cycles since reset, sampled and displayed digits indexed like an[]
  int n = 0;
  int smp_dig[4];
  int lat_dig[4];
  bit smp_ovf, lat_ovf;
  int sd[2] = '{4, 1};
  int bl[2] = '{1, 0};
  logic [6:0] e_seg[2];
  logic [3:0] e_an[2];
  logic       e_dp[2];
  logic       e_bv, e_ovf;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10; default: return 7'h7F;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_edge();
    int s, idx;
    bit blank;
    if (reset) begin
      n = 0;
      for (int i = 0; i < 4; i++) lat_dig[i] = 0;
      lat_ovf = 0;
      for (int k = 0; k < 2; k++) begin
        e_seg[k] = 7'h7F; e_an[k] = 4'hF; e_dp[k] = 1'b1;
      end
      e_bv = 1'b0;
      e_ovf = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        idx = (n / sd[k]) % 4;
        blank = 0;
        if (bl[k] == 1 && idx == 3 && lat_dig[3] == 0) blank = 1;
        if (bl[k] == 1 && idx == 2 && lat_dig[3] == 0 && lat_dig[2] == 0) blank = 1;
        e_seg[k] = blank ? 7'h7F : ref_seg(lat_dig[idx]);
        e_an[k]  = 4'hF & ~(4'h1 << idx);
        e_dp[k]  = (idx == 1) ? 1'b0 : 1'b1;
      end
      if (n % 12 == 0) begin
        s = (int'(cont_seg) > 999) ? 999 : int'(cont_seg);
        smp_dig[3] = s / 100;
        smp_dig[2] = (s / 10) % 10;
        smp_dig[1] = s % 10;
        smp_dig[0] = (int'(cont_dec) > 9) ? 9 : int'(cont_dec);
        smp_ovf = (int'(cont_seg) > 999);
      end
      e_bv = (n % 12 == 11);
      if (n % 12 == 11) begin
        lat_dig = smp_dig;
        lat_ovf = smp_ovf;
      end
      e_ovf = lat_ovf;
      n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("seg0", {9'b0, seg0}, {9'b0, e_seg[0]});
    check_eq("an0",  {12'b0, an0}, {12'b0, e_an[0]});
    check_eq("dp0",  {15'b0, dp0}, {15'b0, e_dp[0]});
    check_eq("seg1", {9'b0, seg1}, {9'b0, e_seg[1]});
    check_eq("an1",  {12'b0, an1}, {12'b0, e_an[1]});
    check_eq("dp1",  {15'b0, dp1}, {15'b0, e_dp[1]});
    check_eq("bcd_valid0", {15'b0, bv0}, {15'b0, e_bv});
    check_eq("bcd_valid1", {15'b0, bv1}, {15'b0, e_bv});
    check_eq("ovf0", {15'b0, ovf0}, {15'b0, e_ovf});
    check_eq("ovf1", {15'b0, ovf1}, {15'b0, e_ovf});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic drive(input int s, input int d);
    cont_seg = 10'(s);
    cont_dec = 4'(d);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0);
    run(3);
    reset = 1'b0;
    run(40);
    drive(437, 6);  run(30);
    drive(5, 3);    run(30);
    drive(999, 9);  run(15);
    drive(1000, 10); run(15);
    drive(1010, 12); run(30);
    drive(12, 0);   run(30);
    drive(100, 0);  run(14);
    for (int i = 0; i < 12 && (n % 12) != 4; i++) tick();
    drive(200, 0);  run(30);
    for (int i = 0; i < 12 && (n % 12) != 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(30);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) drive($urandom_range(0, 1023), $urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
